mul_scheduler: RTL and testbench

- Shares one sequential shift-add multiplier unit among NUM_REQ requesters.
- Grants requesters round-robin, latches the winner's operands, and pulses start to the multiplier.
- Waits for done, with a watchdog, then returns the product to the winner over a valid/ready response channel.
- Sits between the client blocks and the multiplier unit; this block is its only driver.

---
 rtl/mul_sched_pkg.sv | 17 +
 rtl/mul_scheduler_rr_arbiter.sv | 38 +++
 rtl/mul_scheduler.sv | 132 +++++++++++++
 tb/tb_mul_scheduler.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_sched_pkg.sv
// Shared constants for the multiplier scheduler slice.
// FSM encodings and default geometry.
package mul_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE    = 2'b00;
  localparam state_t S_LAUNCH  = 2'b01;
  localparam state_t S_WAIT    = 2'b10;
  localparam state_t S_RESPOND = 2'b11;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 16;
  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_ID_W    = 2;

endpackage

// File: rtl/mul_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping at NUM_REQ-1. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any
);

  localparam logic [ID_W:0] N_EXT = (ID_W+1)'(NUM_REQ);

  logic [ID_W:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = '0;
    if (enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = {1'b0, ptr} + (ID_W+1)'(k);
        if (idx >= N_EXT)
          idx = idx - N_EXT;
        if (!any && req[idx[ID_W-1:0]]) begin
          any                    = 1'b1;
          grant[idx[ID_W-1:0]]   = 1'b1;
          grant_id               = idx[ID_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/mul_scheduler.sv
// Shares one sequential multiplier among NUM_REQ clients: round-robin
// grant, start pulse, watchdog-guarded wait, valid/ready response.
module mul_scheduler
  import mul_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int ID_W    = DEF_ID_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     resp_valid,
  output logic [ID_W-1:0]          resp_id,
  output logic [2*WIDTH-1:0]       resp_product,
  output logic                     resp_error,
  input  logic                     resp_ready,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic                     mul_done,
  input  logic [2*WIDTH-1:0]       mul_product,
  output logic                     busy
);

  localparam int WD_W = $clog2(TIMEOUT) + 1;

  state_t              state;
  state_t              state_nxt;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     grant_id;
  logic [WD_W-1:0]     wd_count;
  logic [NUM_REQ-1:0]  arb_grant;
  logic [ID_W-1:0]     arb_id;
  logic                arb_any;
  logic                arb_en;
  logic                wd_expired;
  logic                accept;
  logic                resp_fire;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .enable   (arb_en),
    .grant    (arb_grant),
    .grant_id (arb_id),
    .any      (arb_any)
  );

  assign wd_expired = (wd_count == WD_W'(TIMEOUT - 1));
  assign accept     = arb_en && arb_any;
  assign resp_fire  = resp_valid && resp_ready;

  always_ff @(posedge clock) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (arb_any) state_nxt = S_LAUNCH;
      S_LAUNCH:  state_nxt = S_WAIT;
      S_WAIT:    if (mul_done || wd_expired) state_nxt = S_RESPOND;
      S_RESPOND: if (resp_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    arb_en     = (state == S_IDLE);
    mul_start  = (state == S_LAUNCH);
    resp_valid = (state == S_RESPOND);
    busy       = (state != S_IDLE);
    req_ready  = arb_grant;
    resp_id    = resp_valid ? grant_id : '0;
  end

  // Operands and winner id are captured on the accept handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      mul_a    <= '0;
      mul_b    <= '0;
      grant_id <= '0;
    end else if (accept) begin
      mul_a    <= req_a[arb_id*WIDTH +: WIDTH];
      mul_b    <= req_b[arb_id*WIDTH +: WIDTH];
      grant_id <= arb_id;
    end
  end

  // A done seen on the timeout cycle takes priority over the error.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_count     <= '0;
      resp_product <= '0;
      resp_error   <= 1'b0;
    end else begin
      if (state == S_LAUNCH)
        wd_count <= '0;
      else if (state == S_WAIT)
        wd_count <= wd_count + 1'b1;

      if (state == S_WAIT) begin
        if (mul_done) begin
          resp_product <= mul_product;
          resp_error   <= 1'b0;
        end else if (wd_expired) begin
          resp_product <= '0;
          resp_error   <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      rr_ptr <= '0;
    else if (resp_fire)
      rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  end

endmodule

// File: tb/tb_mul_scheduler.sv
// Bench for mul_scheduler: behavioural multiplier model plus a
// round-robin reference computed from plain arithmetic.
module tb_mul_scheduler;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 64;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic [N-1:0]    req_ready;
  logic            resp_valid;
  logic [1:0]      resp_id;
  logic [2*W-1:0]  resp_product;
  logic            resp_error;
  logic            resp_ready;
  logic            mul_start;
  logic [W-1:0]    mul_a;
  logic [W-1:0]    mul_b;
  logic            mul_done;
  logic [2*W-1:0]  mul_product;
  logic            busy;

  mul_scheduler #(
    .NUM_REQ (N),
    .WIDTH   (W),
    .TIMEOUT (TO),
    .ID_W    (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_product (resp_product),
    .resp_error   (resp_error),
    .resp_ready   (resp_ready),
    .mul_start    (mul_start),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_done     (mul_done),
    .mul_product  (mul_product),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  int       delay     = 1;
  bit       spur      = 1'b0;
  int       cnt       = 0;
  int       start_cnt = 0;
  logic [W-1:0] hold_a;
  logic [W-1:0] hold_b;
  int       mptr      = 0;
  logic [W-1:0] oa [N];
  logic [W-1:0] ob [N];

  // Multiplier model: done asserted on WAIT cycle number 'delay'
  // (0 = never); optional spurious done during LAUNCH.
  initial begin
    mul_done    = 1'b0;
    mul_product = '0;
    hold_a      = '0;
    hold_b      = '0;
    forever begin
      @(negedge clock);
      if (reset === 1'b1) begin
        cnt      = 0;
        mul_done = 1'b0;
      end else if (mul_start === 1'b1) begin
        start_cnt++;
        cnt    = delay;
        hold_a = mul_a;
        hold_b = mul_b;
        if (spur) begin
          mul_done    = 1'b1;
          mul_product = 32'hDEAD_BEEF;
        end else begin
          mul_done = 1'b0;
        end
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mul_done    = 1'b1;
          mul_product = 32'(hold_a) * 32'(hold_b);
        end else begin
          mul_done = 1'b0;
        end
      end else begin
        mul_done = 1'b0;
      end
    end
  end

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic load_ops();
    for (int i = 0; i < N; i++) begin
      oa[i] = W'($urandom);
      ob[i] = W'($urandom);
      req_a[i*W +: W] = oa[i];
      req_b[i*W +: W] = ob[i];
    end
  endtask

  task automatic wait_resp(input int limit, output int cyc);
    cyc = -1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clock);
      #1;
      if (resp_valid === 1'b1) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    total++;
    if ({req_ready, resp_valid, resp_id, resp_error, mul_start, busy} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 0",
               {req_ready, resp_valid, resp_id, resp_error, mul_start, busy});
    end
    total++;
    if ({resp_product, mul_a, mul_b} !== '0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0", {resp_product, mul_a, mul_b});
    end
    reset = 1'b0;
    mptr  = 0;
  endtask

  task automatic test_single();
    int cyc;
    int s0;
    @(negedge clock);
    delay      = 17;
    spur       = 1'b0;
    resp_ready = 1'b0;
    req_a[0*W +: W] = 16'd7;
    req_b[0*W +: W] = 16'd6;
    req_valid  = 4'b0001;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL single_grant: got %b want 0001", req_ready);
    end
    @(negedge clock);
    req_valid = '0;
    #1;
    s0 = start_cnt;
    total++;
    if (mul_start !== 1'b1 || mul_a !== 16'd7 || mul_b !== 16'd6) begin
      bad++;
      $display("FAIL single_launch: got start=%b a=%0d b=%0d want 1 7 6",
               mul_start, mul_a, mul_b);
    end
    wait_resp(40, cyc);
    total++;
    if (cyc != 18) begin
      bad++;
      $display("FAIL single_latency: got %0d want 18", cyc);
    end
    total++;
    if (resp_id !== 2'd0 || resp_product !== 32'd42 || resp_error !== 1'b0) begin
      bad++;
      $display("FAIL single_resp: got id=%0d p=%0d e=%b want 0 42 0",
               resp_id, resp_product, resp_error);
    end
    total++;
    if (start_cnt != s0) begin
      bad++;
      $display("FAIL single_starts: got %0d want %0d", start_cnt, s0);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    #1;
    total++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_release: got v=%b busy=%b want 0 0", resp_valid, busy);
    end
    mptr = 1;
  endtask

  task automatic test_round_robin();
    int cyc;
    int exp_id;
    logic [N-1:0] pat;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    mptr  = 0;
    spur  = 1'b0;
    resp_ready = 1'b1;
    for (int t = 0; t < 13; t++) begin
      @(negedge clock);
      pat    = (t < 5) ? 4'b1111 : N'($urandom_range(1, 15));
      exp_id = (t < 5) ? (t % N) : rr_pick(pat, mptr);
      delay  = $urandom_range(1, 20);
      load_ops();
      req_valid = pat;
      #1;
      total++;
      if (req_ready !== N'(1 << exp_id)) begin
        bad++;
        $display("FAIL rr_grant[%0d]: got %b want %b", t, req_ready, N'(1 << exp_id));
      end
      @(negedge clock);
      req_valid = '0;
      #1;
      total++;
      if (mul_a !== oa[exp_id] || mul_b !== ob[exp_id]) begin
        bad++;
        $display("FAIL rr_ops[%0d]: got %h %h want %h %h",
                 t, mul_a, mul_b, oa[exp_id], ob[exp_id]);
      end
      wait_resp(40, cyc);
      total++;
      if (cyc != delay + 1 || resp_id !== 2'(exp_id) || resp_error !== 1'b0 ||
          resp_product !== 32'(oa[exp_id]) * 32'(ob[exp_id])) begin
        bad++;
        $display("FAIL rr_resp[%0d]: got cyc=%0d id=%0d p=%h e=%b want %0d %0d %h 0",
                 t, cyc, resp_id, resp_product, resp_error, delay + 1, exp_id,
                 32'(oa[exp_id]) * 32'(ob[exp_id]));
      end
      mptr = (exp_id + 1) % N;
    end
    @(negedge clock);
    resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int cyc;
    int exp_id;
    @(negedge clock);
    delay      = 5;
    resp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 16'd255;
      req_b[i*W +: W] = 16'd255;
    end
    req_valid = 4'b1111;
    exp_id    = mptr;
    #1;
    total++;
    if (req_ready !== N'(1 << exp_id)) begin
      bad++;
      $display("FAIL bp_grant: got %b want %b", req_ready, N'(1 << exp_id));
    end
    wait_resp(30, cyc);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      #1;
      total++;
      if (resp_valid !== 1'b1 || resp_product !== 32'd65025 ||
          resp_id !== 2'(exp_id) || req_ready !== 4'b0000) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got v=%b p=%0d id=%0d rdy=%b want 1 65025 %0d 0000",
                 c, resp_valid, resp_product, resp_id, req_ready, exp_id);
      end
    end
    @(negedge clock);
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    #1;
    mptr = (exp_id + 1) % N;
    total++;
    if (resp_valid !== 1'b0 || req_ready !== N'(1 << mptr)) begin
      bad++;
      $display("FAIL bp_release: got v=%b rdy=%b want 0 %b",
               resp_valid, req_ready, N'(1 << mptr));
    end
    req_valid = '0;
    @(negedge clock);
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_withdraw: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_watchdog();
    int cyc;
    int exp_id;
    logic [2*W-1:0] exp_p;
    for (int v = 0; v < 2; v++) begin
      @(negedge clock);
      delay      = (v == 0) ? 0 : TO;
      resp_ready = 1'b0;
      load_ops();
      req_valid  = N'($urandom_range(1, 15));
      exp_id     = rr_pick(req_valid, mptr);
      exp_p      = (v == 0) ? '0 : 32'(oa[exp_id]) * 32'(ob[exp_id]);
      @(negedge clock);
      req_valid = '0;
      #1;
      wait_resp(100, cyc);
      total++;
      if (cyc != TO + 1) begin
        bad++;
        $display("FAIL wd_latency[%0d]: got %0d want %0d", v, cyc, TO + 1);
      end
      total++;
      if (resp_error !== (v == 0) || resp_product !== exp_p || resp_id !== 2'(exp_id)) begin
        bad++;
        $display("FAIL wd_resp[%0d]: got e=%b p=%h id=%0d want %0d %h %0d",
                 v, resp_error, resp_product, resp_id, (v == 0), exp_p, exp_id);
      end
      resp_ready = 1'b1;
      @(negedge clock);
      resp_ready = 1'b0;
      mptr = (exp_id + 1) % N;
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    @(negedge clock);
    delay     = 0;
    load_ops();
    req_valid = 4'b1000;
    @(negedge clock);
    req_valid = '0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    mptr  = 0;
    #1;
    total++;
    if ({req_ready, resp_valid, resp_id, resp_error, mul_start, busy} !== '0 ||
        {resp_product, mul_a, mul_b} !== '0) begin
      bad++;
      $display("FAIL midrst_zero: got ctrl=%b data=%h want 0",
               {req_ready, resp_valid, resp_id, resp_error, mul_start, busy},
               {resp_product, mul_a, mul_b});
    end
    req_valid = 4'b0100;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL midrst_grant2: got %b want 0100", req_ready);
    end
    delay     = 2;
    req_valid = 4'b1111;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL midrst_ptr0: got %b want 0001", req_ready);
    end
    @(negedge clock);
    req_valid = '0;
    #1;
    wait_resp(20, cyc);
    total++;
    if (cyc != 3 || resp_id !== 2'd0 || resp_product !== 32'(oa[0]) * 32'(ob[0])) begin
      bad++;
      $display("FAIL midrst_resp: got cyc=%0d id=%0d p=%h want 3 0 %h",
               cyc, resp_id, resp_product, 32'(oa[0]) * 32'(ob[0]));
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    mptr = 1;
  endtask

  task automatic test_spurious();
    int cyc;
    int exp_id;
    int extra;
    int s0;
    @(negedge clock);
    delay     = 3;
    spur      = 1'b1;
    load_ops();
    req_valid = N'(1 << mptr);
    exp_id    = mptr;
    @(negedge clock);
    req_valid = '0;
    #1;
    s0   = start_cnt;
    spur = 1'b0;
    wait_resp(20, cyc);
    total++;
    if (cyc != 4 || resp_error !== 1'b0 ||
        resp_product !== 32'(oa[exp_id]) * 32'(ob[exp_id])) begin
      bad++;
      $display("FAIL spur_resp: got cyc=%0d p=%h e=%b want 4 %h 0",
               cyc, resp_product, resp_error, 32'(oa[exp_id]) * 32'(ob[exp_id]));
    end
    resp_ready = 1'b1;
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      #1;
      if (resp_valid === 1'b1 || busy === 1'b1) extra++;
    end
    resp_ready = 1'b0;
    total++;
    if (extra != 0 || start_cnt != s0) begin
      bad++;
      $display("FAIL spur_single: got extra=%0d starts=%0d want 0 %0d",
               extra, start_cnt, s0);
    end
    mptr = (exp_id + 1) % N;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_watchdog();
    test_reset_mid();
    test_spurious();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
